// File: rtl/sbox_pipe.sv
// Four-stage composite-field AES SubBytes / InvSubBytes engine, LANES bytes per beat,
// with a single global stall driven by the output handshake.

module sbox_gf4_mul (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [3:0] p
);
    logic c0, c1, c2, c3, c4, c5, c6;

    assign c0 = a[0] & b[0];
    assign c1 = (a[1] & b[0]) ^ (a[0] & b[1]);
    assign c2 = (a[2] & b[0]) ^ (a[1] & b[1]) ^ (a[0] & b[2]);
    assign c3 = (a[3] & b[0]) ^ (a[2] & b[1]) ^ (a[1] & b[2]) ^ (a[0] & b[3]);
    assign c4 = (a[3] & b[1]) ^ (a[2] & b[2]) ^ (a[1] & b[3]);
    assign c5 = (a[3] & b[2]) ^ (a[2] & b[3]);
    assign c6 = a[3] & b[3];

    // reduce modulo x^4 + x + 1
    assign p = {c3 ^ c6, c2 ^ c5 ^ c6, c1 ^ c4 ^ c5, c0 ^ c4};
endmodule

module sbox_pipe #(
    parameter int LANES = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_inv,
    input  logic [8*LANES-1:0] in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [8*LANES-1:0] out_data,
    output logic               busy
);
    // Composite field: GF(2^4) mod x^4+x+1, then y^2 + y + LAMBDA over it.
    localparam logic [3:0] LAMBDA = 4'hC;

    function automatic logic [3:0] gf4_mul(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] p;
        logic [3:0] t;
        p = '0;
        t = a;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) p = p ^ t;
            t = {t[2:0], 1'b0} ^ {2'b00, t[3], t[3]};
        end
        return p;
    endfunction

    // a^14 is the inverse for a != 0 and maps 0 to 0
    function automatic logic [3:0] gf4_inv(input logic [3:0] a);
        logic [3:0] a2, a4, a8;
        a2 = gf4_mul(a, a);
        a4 = gf4_mul(a2, a2);
        a8 = gf4_mul(a4, a4);
        return gf4_mul(gf4_mul(a8, a4), a2);
    endfunction

    function automatic logic [7:0] cf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [3:0] hh;
        hh = gf4_mul(a[7:4], b[7:4]);
        return {hh ^ gf4_mul(a[7:4], b[3:0]) ^ gf4_mul(a[3:0], b[7:4]),
                gf4_mul(hh, LAMBDA) ^ gf4_mul(a[3:0], b[3:0])};
    endfunction

    // GF(2)-linear map; column i of m is m[8i+7:8i]
    function automatic logic [7:0] lin_map(input logic [63:0] m, input logic [7:0] b);
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < 8; i++)
            if (b[i]) r = r ^ m[8*i +: 8];
        return r;
    endfunction

    // Isomorphism columns are the powers of a composite-field root of the AES polynomial.
    function automatic logic [63:0] find_iso();
        logic [63:0] m;
        logic [63:0] cols;
        logic [7:0]  pw;
        logic [7:0]  acc;
        logic [7:0]  c8;
        logic        found;
        m     = '0;
        cols  = '0;
        found = 1'b0;
        for (int c = 2; c < 256; c++) begin
            if (!found) begin
                c8  = c[7:0];
                pw  = 8'h01;
                acc = '0;
                for (int k = 0; k < 9; k++) begin
                    if (k < 8) cols[8*k +: 8] = pw;
                    if (k == 0 || k == 1 || k == 3 || k == 4 || k == 8) acc = acc ^ pw;
                    pw = cf_mul(pw, c8);
                end
                if (acc == 8'h00) begin
                    found = 1'b1;
                    m     = cols;
                end
            end
        end
        return m;
    endfunction

    function automatic logic [63:0] find_iso_inv(input logic [63:0] m);
        logic [63:0] r;
        r = '0;
        for (int j = 0; j < 8; j++)
            for (int b = 0; b < 256; b++)
                if (lin_map(m, b[7:0]) == (8'h01 << j)) r[8*j +: 8] = b[7:0];
        return r;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic logic [7:0] fwd_mix(input logic [7:0] b);
        return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4);
    endfunction

    function automatic logic [7:0] inv_mix(input logic [7:0] b);
        return rotl(b, 1) ^ rotl(b, 3) ^ rotl(b, 6);
    endfunction

    localparam logic [63:0] ISO_M     = find_iso();
    localparam logic [63:0] ISO_INV_M = find_iso_inv(ISO_M);

    logic adv;
    logic s1_v, s2_v, s3_v;
    logic s1_inv, s2_inv, s3_inv;

    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;
    assign busy     = s1_v | s2_v | s3_v | out_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v      <= 1'b0;
            s2_v      <= 1'b0;
            s3_v      <= 1'b0;
            out_valid <= 1'b0;
            s1_inv    <= 1'b0;
            s2_inv    <= 1'b0;
            s3_inv    <= 1'b0;
        end else if (adv) begin
            s1_v      <= in_valid;
            s2_v      <= s1_v;
            s3_v      <= s2_v;
            out_valid <= s3_v;
            s1_inv    <= in_inv;
            s2_inv    <= s1_inv;
            s3_inv    <= s2_inv;
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [7:0] x_in, pre, iso;
        logic [3:0] s1_h, s1_l;
        logic [3:0] hl, dlt;
        logic [3:0] s2_h, s2_lh, s2_d;
        logic [3:0] hp, lp;
        logic [3:0] s3_hp, s3_lp;
        logic [7:0] y, s4_q;

        assign x_in = in_data[8*i +: 8];
        assign pre  = in_inv ? (inv_mix(x_in) ^ 8'h05) : x_in;
        assign iso  = lin_map(ISO_M, pre);

        // norm of (h*y + l); zero input gives delta = 0 and hence a zero inverse
        sbox_gf4_mul u_mul_hl (.a(s1_h), .b(s1_l), .p(hl));
        assign dlt = gf4_mul(gf4_mul(s1_h, s1_h), LAMBDA) ^ hl ^ gf4_mul(s1_l, s1_l);

        sbox_gf4_mul u_mul_h (.a(s2_h),  .b(s2_d), .p(hp));
        sbox_gf4_mul u_mul_l (.a(s2_lh), .b(s2_d), .p(lp));

        assign y = lin_map(ISO_INV_M, {s3_hp, s3_lp});

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s1_h  <= '0;
                s1_l  <= '0;
                s2_h  <= '0;
                s2_lh <= '0;
                s2_d  <= '0;
                s3_hp <= '0;
                s3_lp <= '0;
                s4_q  <= '0;
            end else if (adv) begin
                s1_h  <= iso[7:4];
                s1_l  <= iso[3:0];
                s2_h  <= s1_h;
                s2_lh <= s1_l ^ s1_h;
                s2_d  <= gf4_inv(dlt);
                s3_hp <= hp;
                s3_lp <= lp;
                s4_q  <= s3_inv ? y : (fwd_mix(y) ^ 8'h63);
            end
        end

        assign out_data[8*i +: 8] = s4_q;
    end
endmodule

// File: tb/tb_sbox_pipe.sv
// Bench for sbox_pipe: fixed vector table, exhaustive sweep, backpressure, mixed modes,
// mid-flight reset and random traffic against a GF(2^8) reference model.

module tb_sbox_pipe;
    localparam int LANES = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_inv;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        busy;

    sbox_pipe #(.LANES(LANES)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_inv(in_inv), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0]  sbox_t [256];
    logic [7:0]  isbox_t [256];
    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];
    logic        hold_chk = 1'b0;
    logic [31:0] hold_data = '0;

    typedef struct {
        logic        inv;
        logic [31:0] din;
        logic [31:0] dout;
    } vec_t;

    vec_t tbl [10];

    // ---------------- reference model: plain GF(2^8) arithmetic ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] t;
        p = '0;
        t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ t;
            t = t[7] ? ((t << 1) ^ 8'h1B) : (t << 1);
        end
        return p;
    endfunction

    function automatic logic [7:0] ginv(input logic [7:0] a);
        if (a == 8'h00) return 8'h00;
        for (int b = 1; b < 256; b++)
            if (gmul(a, b[7:0]) == 8'h01) return b[7:0];
        return 8'h00;
    endfunction

    function automatic logic [7:0] affine(input logic [7:0] b);
        logic [7:0] c;
        logic [7:0] r;
        c = 8'h63;
        for (int i = 0; i < 8; i++)
            r[i] = b[i] ^ b[(i+4)%8] ^ b[(i+5)%8] ^ b[(i+6)%8] ^ b[(i+7)%8] ^ c[i];
        return r;
    endfunction

    function automatic logic [31:0] model(input logic [31:0] d, input logic inv);
        logic [31:0] r;
        for (int i = 0; i < LANES; i++)
            r[8*i +: 8] = inv ? isbox_t[d[8*i +: 8]] : sbox_t[d[8*i +: 8]];
        return r;
    endfunction

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // One cycle: drive at posedge+1, sample at negedge, return at next posedge+1.
    task automatic step(input logic v, input logic inv, input logic [31:0] d,
                        input logic ordy, output logic acc);
        logic [31:0] e;
        in_valid  = v;
        in_inv    = inv;
        in_data   = d;
        out_ready = ordy;
        @(negedge clk);
        if (hold_chk) begin
            chk("stall_valid", {31'b0, out_valid}, 32'd1);
            chk("stall_data", out_data, hold_data);
        end
        hold_chk  = out_valid && !out_ready;
        hold_data = out_data;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out", out_data, 32'hxxxxxxxx);
            end else begin
                e = exp_q.pop_front();
                chk("out_data", out_data, e);
                got_q.push_back(out_data);
            end
        end
        acc = v && in_ready;
        if (acc) exp_q.push_back(model(d, inv));
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        logic a;
        for (int k = 0; k < 40 && exp_q.size() > 0; k++) step(1'b0, 1'b0, 32'h0, 1'b1, a);
        chk("drain_left", exp_q.size(), 32'd0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic        acc;
        int          n;
        int          idx;
        int          cyc;
        logic [31:0] words [64];
        logic [31:0] fwd_out [64];
        logic [31:0] w;

        rst_n = 1'b0;
        in_valid = 1'b0;
        in_inv = 1'b0;
        in_data = '0;
        out_ready = 1'b1;

        for (int x = 0; x < 256; x++) sbox_t[x] = affine(ginv(x[7:0]));
        for (int x = 0; x < 256; x++) isbox_t[sbox_t[x]] = x[7:0];

        tbl[0] = '{1'b0, 32'hFF000153, 32'h16637CED};
        tbl[1] = '{1'b1, 32'h16637CED, 32'hFF000153};
        tbl[2] = '{1'b0, 32'h53535353, 32'hEDEDEDED};
        tbl[3] = '{1'b1, 32'h53535353, 32'h50505050};
        tbl[4] = '{1'b0, 32'h03020100, 32'h7B777C63};
        tbl[5] = '{1'b0, 32'h07060504, 32'hC56F6BF2};
        tbl[6] = '{1'b1, 32'h03020100, 32'hD56A0952};
        tbl[7] = '{1'b0, 32'h00000000, 32'h63636363};
        tbl[8] = '{1'b1, 32'h63636363, 32'h00000000};
        tbl[9] = '{1'b0, 32'hAB201110, 32'h62B782CA};

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_out_data", out_data, 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1;

        // fixed vectors with latency check
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_inv = tbl[i].inv;
            in_data = tbl[i].din;
            out_ready = 1'b1;
            @(negedge clk);
            chk("tbl_in_ready", {31'b0, in_ready}, 32'd1);
            @(posedge clk);
            #1 in_valid = 1'b0;
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!out_valid && n < 12);
            chk("tbl_latency", n, 32'd4);
            chk("tbl_data", out_data, tbl[i].dout);
            @(posedge clk);
            #1;
        end

        // exhaustive sweep, forward then inverse of the forward results
        for (int k = 0; k < 64; k++)
            words[k] = {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)};
        got_q.delete();
        for (int k = 0; k < 64; k++) step(1'b1, 1'b0, words[k], 1'b1, acc);
        drain();
        chk("sweep_fwd_count", got_q.size(), 32'd64);
        for (int k = 0; k < 64; k++) fwd_out[k] = (k < got_q.size()) ? got_q[k] : 32'h0;
        for (int k = 0; k < 64; k++) step(1'b1, 1'b0 ^ 1'b1, words[k], 1'b1, acc);
        drain();
        got_q.delete();
        for (int k = 0; k < 64; k++) step(1'b1, 1'b1, fwd_out[k], 1'b1, acc);
        drain();
        chk("roundtrip_count", got_q.size(), 32'd64);
        for (int k = 0; k < 64 && k < got_q.size(); k++)
            if (got_q[k] !== words[k]) chk("roundtrip", got_q[k], words[k]);

        // backpressure: out_ready pattern 1,0,0
        got_q.delete();
        idx = 0;
        cyc = 0;
        while (idx < 10 && cyc < 200) begin
            step(1'b1, idx[0], 32'h1000_0000 + 32'(idx * 32'h01030507), (cyc % 3) == 0, acc);
            if (acc) idx++;
            cyc++;
        end
        chk("bp_sent", idx, 32'd10);
        for (int k = 0; k < 40 && exp_q.size() > 0; k++) begin
            step(1'b0, 1'b0, 32'h0, (k % 3) == 0, acc);
        end
        drain();
        chk("bp_count", got_q.size(), 32'd10);

        // fill with out_ready = 0, then accept-and-emit in the same cycle
        n = 0;
        for (int k = 0; k < 6; k++) begin
            step(1'b1, 1'b0, $urandom, 1'b0, acc);
            if (acc) n++;
        end
        chk("fill_count", n, 32'd4);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("full_in_ready", {31'b0, in_ready}, 32'd0);
            chk("full_busy", {31'b0, busy}, 32'd1);
            @(posedge clk);
            #1;
        end
        step(1'b1, 1'b1, $urandom, 1'b1, acc);
        chk("simul_accept", {31'b0, acc}, 32'd1);
        drain();

        // mixed modes
        got_q.delete();
        for (int k = 0; k < 6; k++) step(1'b1, k[0], 32'h53535353, 1'b1, acc);
        drain();
        for (int k = 0; k < 6 && k < got_q.size(); k++) begin
            w = k[0] ? 32'h50505050 : 32'hEDEDEDED;
            chk("mixed", got_q[k], w);
        end

        // random traffic
        for (int k = 0; k < 400; k++)
            step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom,
                 $urandom_range(0, 3) != 0, acc);
        drain();

        // reset with three beats in flight
        for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 32'hDEAD0000 + 32'(k), 1'b1, acc);
        in_valid = 1'b0;
        chk("pre_rst_busy", {31'b0, busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("midrst_busy", {31'b0, busy}, 32'd0);
        exp_q.delete();
        hold_chk = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int k = 0; k < 6; k++) step(1'b0, 1'b0, 32'h0, 1'b1, acc);
        got_q.delete();
        step(1'b1, 1'b0, 32'hFF000153, 1'b1, acc);
        drain();
        chk("post_rst_first", (got_q.size() > 0) ? got_q[0] : 32'h0, 32'h16637CED);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
